// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared AES decryption types, round-count constants and GF(2^8) helpers.
package aes_inv_round_ctrl_pkg;

    localparam int unsigned AES128_NR = 10;
    localparam int unsigned AES192_NR = 12;
    localparam int unsigned AES256_NR = 14;

    localparam int unsigned BLK_W     = 128;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned NUM_BYTES = BLK_W / BYTE_W;

    typedef logic [BLK_W-1:0]  aes_block_t;
    typedef logic [BYTE_W-1:0] aes_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } dec_state_e;

    function automatic aes_byte_t gf_xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p;
        aes_byte_t x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = gf_xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic aes_byte_t gf_inv(input aes_byte_t x);
        aes_byte_t r;
        aes_byte_t p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic aes_byte_t inv_sbox(input aes_byte_t s);
        aes_byte_t a;
        a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(a);
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Command, key-store and plaintext ports of the AES inverse-round sequencer.
interface aes_inv_round_ctrl_if
    import aes_inv_round_ctrl_pkg::*;
#(
    parameter int unsigned RK_IDX_W = 4
);
    logic                in_valid;
    logic                in_ready;
    aes_block_t          in_data;
    logic [RK_IDX_W-1:0] rk_idx;
    aes_block_t          rk;
    logic                abort;
    logic                out_valid;
    logic                out_ready;
    aes_block_t          out_data;
    logic                busy;

    modport master (
        output in_valid, in_data, rk, abort, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, rk, abort, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_round_ctrl_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns (skipped when i_last).
module aes_inv_round_ctrl_inv_round
    import aes_inv_round_ctrl_pkg::*;
(
    input  aes_block_t i_blk,
    input  aes_block_t i_rk,
    input  logic       i_last,
    output aes_block_t o_blk
);

    aes_byte_t w_sr [NUM_BYTES];
    aes_byte_t w_ak [NUM_BYTES];
    aes_byte_t w_mc [NUM_BYTES];

    // Byte gi sits at row gi%4, column gi/4; row r rotates right by r.
    for (genvar gi = 0; gi < int'(NUM_BYTES); gi++) begin : g_byte
        localparam int ROW = gi % 4;
        localparam int COL = gi / 4;
        localparam int SRC = ROW + 4 * ((COL + 4 - ROW) % 4);

        assign w_sr[gi] = i_blk[int'(BLK_W) - 1 - int'(BYTE_W) * SRC -: BYTE_W];
        assign w_ak[gi] = inv_sbox(w_sr[gi]) ^ i_rk[int'(BLK_W) - 1 - int'(BYTE_W) * gi -: BYTE_W];
        assign o_blk[int'(BLK_W) - 1 - int'(BYTE_W) * gi -: BYTE_W] = i_last ? w_ak[gi] : w_mc[gi];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign w_mc[4*gc+0] = gf_mul(8'h0e, w_ak[4*gc+0]) ^ gf_mul(8'h0b, w_ak[4*gc+1])
                            ^ gf_mul(8'h0d, w_ak[4*gc+2]) ^ gf_mul(8'h09, w_ak[4*gc+3]);
        assign w_mc[4*gc+1] = gf_mul(8'h09, w_ak[4*gc+0]) ^ gf_mul(8'h0e, w_ak[4*gc+1])
                            ^ gf_mul(8'h0b, w_ak[4*gc+2]) ^ gf_mul(8'h0d, w_ak[4*gc+3]);
        assign w_mc[4*gc+2] = gf_mul(8'h0d, w_ak[4*gc+0]) ^ gf_mul(8'h09, w_ak[4*gc+1])
                            ^ gf_mul(8'h0e, w_ak[4*gc+2]) ^ gf_mul(8'h0b, w_ak[4*gc+3]);
        assign w_mc[4*gc+3] = gf_mul(8'h0b, w_ak[4*gc+0]) ^ gf_mul(8'h0d, w_ak[4*gc+1])
                            ^ gf_mul(8'h09, w_ak[4*gc+2]) ^ gf_mul(8'h0e, w_ak[4*gc+3]);
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES decryption sequencer: one inverse round per clock, round keys fetched by index.
// Build option AES_DEC_ZEROIZE_EN clears the state register when leaving DONE or on abort.
module aes_inv_round_ctrl
    import aes_inv_round_ctrl_pkg::*;
#(
    parameter int unsigned NR       = AES128_NR,
    parameter int unsigned RK_IDX_W = 4
)(
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  bus
);

    dec_state_e          r_fsm;
    logic [RK_IDX_W-1:0] r_round;
    aes_block_t          r_data;

    logic                w_last;
    aes_block_t          w_round_blk;

    assign w_last = (r_round == '0);

    aes_inv_round_ctrl_inv_round u_inv_round (
        .i_blk  (r_data),
        .i_rk   (bus.rk),
        .i_last (w_last),
        .o_blk  (w_round_blk)
    );

    // Abort takes priority in every state; in IDLE it also masks in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_round <= '0;
            r_data  <= '0;
        end else if (bus.abort) begin
            r_fsm <= IDLE;
`ifdef AES_DEC_ZEROIZE_EN
            r_data <= '0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data  <= bus.in_data ^ bus.rk;
                        r_round <= RK_IDX_W'(NR - 1);
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_data <= w_round_blk;
                    if (w_last) r_fsm <= DONE;
                    else        r_round <= r_round - RK_IDX_W'(1);
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_fsm <= IDLE;
`ifdef AES_DEC_ZEROIZE_EN
                        r_data <= '0;
`endif
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign bus.rk_idx    = (r_fsm == ROUND) ? r_round :
                           (r_fsm == DONE)  ? '0      : RK_IDX_W'(NR);
    assign bus.in_ready  = (r_fsm == IDLE) && !bus.abort;
    assign bus.out_valid = (r_fsm == DONE);
    assign bus.out_data  = (r_fsm == DONE) ? r_data : '0;
    assign bus.busy      = (r_fsm != IDLE);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Directed bench for aes_inv_round_ctrl: FIPS-197 C.1, backpressure, back-to-back, abort and reset.
module tb_aes_inv_round_ctrl;
    import aes_inv_round_ctrl_pkg::*;

    localparam int unsigned NR       = 10;
    localparam int unsigned RK_IDX_W = 4;

    localparam aes_block_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_inv_round_ctrl_if #(.RK_IDX_W(RK_IDX_W)) bus ();

    aes_inv_round_ctrl #(.NR(NR), .RK_IDX_W(RK_IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    aes_block_t rk_mem [NR+1];
    logic [7:0] sbox_t [256];
    aes_block_t b2b_pt [4];
    aes_block_t b2b_ct [4];

    // Key store: combinational lookup of the expanded schedule.
    assign bus.rk = (bus.rk_idx <= RK_IDX_W'(NR)) ? rk_mem[bus.rk_idx] : '0;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic key_expand(input aes_block_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= int'(NR); r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward cipher, used to derive ciphertexts for chosen plaintexts.
    function automatic aes_block_t aes_enc(input aes_block_t pt);
        aes_block_t s;
        aes_block_t t;
        logic [7:0] a [4];
        s = pt ^ rk_mem[0];
        for (int r = 1; r <= int'(NR); r++) begin
            for (int i = 0; i < 16; i++) t[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[127-8*(row+4*col) -: 8] = t[127-8*(row+4*((col+row)%4)) -: 8];
            if (r < int'(NR)) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
                    s[127-8*(4*c+0) -: 8] = xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3];
                    s[127-8*(4*c+1) -: 8] = a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3];
                    s[127-8*(4*c+2) -: 8] = a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3];
                    s[127-8*(4*c+3) -: 8] = xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3]);
                end
            end
            s = s ^ rk_mem[r];
        end
        return s;
    endfunction

    // Offers one block with out_ready high and checks latency, rk_idx sequence and result.
    task automatic run_block(input aes_block_t ct, input aes_block_t pt, input string nm);
        int   k;
        logic seq_ok;
        logic rnd_ok;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = ct;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.rk_idx !== RK_IDX_W'(NR)) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b rk_idx=%0d, required 1 and %0d", nm, bus.in_ready, bus.rk_idx, NR);
        end
        k = 0;
        seq_ok = 1'b1;
        rnd_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                bus.in_valid = 1'b0;
                bus.in_data  = ~ct;
            end
            if (bus.out_valid !== 1'b1) begin
                if (bus.rk_idx !== RK_IDX_W'(int'(NR) - k)) seq_ok = 1'b0;
                if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) rnd_ok = 1'b0;
            end
        end
        checks++;
        if (k != 11 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: out_valid after %0d cycles (valid=%b), required 11", nm, k, bus.out_valid);
        end
        checks++;
        if (!seq_ok) begin
            errors++;
            $display("FAIL %s rk_idx_seq: sequence deviated, required %0d down to 0", nm, NR - 1);
        end
        checks++;
        if (!rnd_ok) begin
            errors++;
            $display("FAIL %s round_flags: in_ready/busy wrong during rounds, required 0/1", nm);
        end
        checks++;
        if (bus.out_data !== pt) begin
            errors++;
            $display("FAIL %s out_data: got %h required %h", nm, bus.out_data, pt);
        end
        checks++;
        if (bus.rk_idx !== '0) begin
            errors++;
            $display("FAIL %s done_rk_idx: got %0d required 0", nm, bus.rk_idx);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_handshake: valid=%b data=%h busy=%b, required 0/0/0", nm, bus.out_valid, bus.out_data, bus.busy);
        end
`ifdef AES_DEC_ZEROIZE_EN
        checks++;
        if (dut.r_data !== '0) begin
            errors++;
            $display("FAIL %s zeroize: state_q=%h required 0", nm, dut.r_data);
        end
`endif
    endtask

    // Waits (bounded) for out_valid at a negedge; returns cycles waited.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.busy !== 1'b0 || bus.rk_idx !== RK_IDX_W'(NR)) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b out_data=%h busy=%b rk_idx=%0d, required 1/0/0/0/%0d",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.rk_idx, NR);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0/1", bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_fips_c1();
        run_block(C1_CT, C1_PT, "c1");
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = C1_CT;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(n);
        for (int j = 0; j < 5; j++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== C1_PT || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h in_ready=%b, required 1/%h/0", j, bus.out_valid, bus.out_data, bus.in_ready, C1_PT);
            end
            if (j < 4) @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        int bi;
        int oi;
        int cyc;
        int last;
        bi = 0; oi = 0; cyc = 0; last = 0;
        bus.out_ready = 1'b1;
        while (oi < 4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (bus.out_data !== b2b_pt[oi]) begin
                    errors++;
                    $display("FAIL b2b_data[%0d]: got %h required %h", oi, bus.out_data, b2b_pt[oi]);
                end
                if (oi > 0) begin
                    checks++;
                    if (cyc - last != 12) begin
                        errors++;
                        $display("FAIL b2b_period[%0d]: got %0d cycles required 12", oi, cyc - last);
                    end
                end
                last = cyc;
                oi++;
            end
            if (bi < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = b2b_ct[bi];
                if (bus.in_ready === 1'b1) bi++;
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (oi != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs required 4", oi);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int   n;
        logic quiet;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = b2b_ct[2];
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.rk_idx !== RK_IDX_W'(4) && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.rk_idx !== RK_IDX_W'(NR)) begin
            errors++;
            $display("FAIL abort_round: busy=%b valid=%b rk_idx=%0d, required 0/0/%0d", bus.busy, bus.out_valid, bus.rk_idx, NR);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_masks_ready: in_ready=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_beats_accept: busy=%b required 0", bus.busy);
        end
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        quiet = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL abort_no_output: out_valid seen after abort, required none");
        end
        run_block(C1_CT, C1_PT, "after_abort");
        // Abort in DONE together with out_ready: the transfer still completes.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = b2b_ct[3];
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_valid(n);
        bus.abort     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== b2b_pt[3]) begin
            errors++;
            $display("FAIL abort_done_xfer: valid=%b data=%h required 1/%h", bus.out_valid, bus.out_data, b2b_pt[3]);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_done_idle: valid=%b busy=%b required 0/0", bus.out_valid, bus.busy);
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = C1_CT;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.busy !== 1'b0 || bus.rk_idx !== RK_IDX_W'(NR)) begin
            errors++;
            $display("FAIL reset_mid_outputs: in_ready=%b valid=%b data=%h busy=%b rk_idx=%0d, required 1/0/0/0/%0d",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.rk_idx, NR);
        end
        checks++;
        if (dut.r_round !== '0 || dut.r_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_regs: round_q=%0d state_q=%h required 0/0", dut.r_round, dut.r_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_block(C1_CT, C1_PT, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        build_sbox();
        key_expand(C1_KEY);
        b2b_pt[0] = C1_PT;
        b2b_pt[1] = 128'h0;
        b2b_pt[2] = 128'hffffffffffffffffffffffffffffffff;
        b2b_pt[3] = 128'h0123456789abcdeffedcba9876543210;
        for (int i = 0; i < 4; i++) b2b_ct[i] = aes_enc(b2b_pt[i]);

        test_reset();
        test_fips_c1();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
